// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: START, DATA (via external serializer), optional PARITY, STOP, with serializer watchdog.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int unsigned WDOG_W     = $clog2(DATA_WIDTH + 2);
    localparam int unsigned WDOG_LIMIT = DATA_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WDOG_W-1:0]   wdog;
    logic                accept;
    logic                timeout;

`ifdef UART_TX_PARITY_EN
    logic                par_en_q;
    logic                par_bit_q;
`else
    logic                unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // New words are only taken while the line is idle or finishing a stop bit.
    assign accept  = data_valid && ((state == IDLE) || (state == STOP));
    assign timeout = (state == DATA) && !ser_done && (wdog == WDOG_W'(WDOG_LIMIT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = DATA;
            end
            DATA: begin
                if (ser_done) begin
`ifdef UART_TX_PARITY_EN
                    state_next = par_en_q ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_next = STOP;
            end
`endif
            STOP: begin
                state_next = data_valid ? START : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from state; during DATA the line follows the serializer.
    always_comb begin
        TX_OUT = 1'b1;
        busy   = 1'b0;
        ser_en = 1'b0;
        case (state)
            START: begin
                TX_OUT = 1'b0;
                busy   = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                TX_OUT = par_bit_q;
                busy   = 1'b1;
            end
`endif
            STOP: begin
                busy = 1'b1;
            end
            default: begin
                TX_OUT = 1'b1;
            end
        endcase
    end

    // Word/config latches, watchdog and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_p_data  <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
        end else begin
            err_timeout <= timeout;
            wdog        <= (state == DATA) ? (wdog + WDOG_W'(1)) : '0;
            if (accept) begin
                ser_p_data <= P_DATA;
`ifdef UART_TX_PARITY_EN
                par_en_q   <= PAR_EN;
                par_bit_q  <= (^P_DATA) ^ PAR_TYP;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with a behavioural LSB-first serializer.
// Expectations follow the build: UART_TX_PARITY_EN defined or not.
module tb_uart_tx_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          ser_done;
    logic          ser_data;
    logic          ser_en;
    logic [DW-1:0] ser_p_data;
    logic          TX_OUT;
    logic          busy;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    logic [3:0] cnt;
    logic       no_done = 1'b0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .ser_p_data (ser_p_data),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    // Serializer model: one bit per enabled cycle, done on the last bit.
    always_ff @(posedge clk) begin
        if (!ser_en) cnt <= 4'd0;
        else         cnt <= cnt + 4'd1;
    end
    assign ser_data = ser_p_data[cnt[2:0]];
    assign ser_done = ser_en && (cnt == 4'd7) && !no_done;

`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    // Expected line bits, bit i = cycle i after accept (START first).
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic with_par, input logic par);
        if (with_par) return {1'b1, par, d, 1'b0};
        return {2'b11, d, 1'b0};
    endfunction

    task automatic accept_word(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        data_valid = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the negedge of the START cycle; leaves at the negedge after the last frame cycle.
    task automatic check_frame(input logic [10:0] exp, input int len, input logic [7:0] word, input string name);
        for (int i = 0; i < len; i++) begin
            checks++;
            if (TX_OUT !== exp[i]) begin
                errors++;
                $display("FAIL %s tx cycle %0d: got %b expected %b", name, i, TX_OUT, exp[i]);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, i, busy);
            end
            if (i == 1) begin
                checks++;
                if (ser_p_data !== word) begin
                    errors++;
                    $display("FAIL %s ser_p_data: got %h expected %h", name, ser_p_data, word);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({TX_OUT, busy, ser_en} !== 3'b100) begin
            errors++;
            $display("FAIL %s idle {tx,busy,ser_en}: got %b expected 100", name, {TX_OUT, busy, ser_en});
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        data_valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        checks++;
        if ({err_timeout, ser_p_data} !== 9'h000) begin
            errors++;
            $display("FAIL reset regs {err,ser_p_data}: got %h expected 000", {err_timeout, ser_p_data});
        end
        rst        = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check_idle("reset_release");
        checks++;
        if (ser_p_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_discard ser_p_data: got %h expected 00", ser_p_data);
        end
    endtask

    task automatic test_frame_a5;
        accept_word(8'hA5, 1'b1, 1'b0);
        data_valid = 1'b0;
        if (HAS_PAR) check_frame(11'b10101001010, 11, 8'hA5, "a5_par");
        else         check_frame(11'b11101001010, 10, 8'hA5, "a5_nopar");
        check_idle("a5_after");
    endtask

    task automatic test_parity_types;
        accept_word(8'h8F, 1'b1, 1'b1);
        data_valid = 1'b0;
        check_frame(frame_bits(8'h8F, HAS_PAR, 1'b0), HAS_PAR ? 11 : 10, 8'h8F, "8f_odd");
        check_idle("8f_after");
        accept_word(8'h9E, 1'b1, 1'b0);
        data_valid = 1'b0;
        check_frame(frame_bits(8'h9E, HAS_PAR, 1'b1), HAS_PAR ? 11 : 10, 8'h9E, "9e_even");
        check_idle("9e_after");
        accept_word(8'h3C, 1'b0, 1'b1);
        data_valid = 1'b0;
        check_frame(frame_bits(8'h3C, 1'b0, 1'b0), 10, 8'h3C, "3c_nopar");
        check_idle("3c_after");
    endtask

    task automatic test_back_to_back;
        accept_word(8'h8F, 1'b1, 1'b1);
        // Held request with a new word: ignored mid-frame, taken in STOP.
        P_DATA  = 8'h9E;
        PAR_TYP = 1'b0;
        check_frame(frame_bits(8'h8F, HAS_PAR, 1'b0), HAS_PAR ? 11 : 10, 8'h8F, "b2b_first");
        data_valid = 1'b0;
        check_frame(frame_bits(8'h9E, HAS_PAR, 1'b1), HAS_PAR ? 11 : 10, 8'h9E, "b2b_second");
        check_idle("b2b_after");
    endtask

    task automatic test_reset_mid_frame;
        accept_word(8'hA5, 1'b1, 1'b0);
        data_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        checks++;
        if ({TX_OUT, ser_en} !== 2'b01) begin
            errors++;
            $display("FAIL midrst bit4 {tx,ser_en}: got %b expected 01", {TX_OUT, ser_en});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
        checks++;
        if ({err_timeout, ser_p_data} !== 9'h000) begin
            errors++;
            $display("FAIL midrst regs {err,ser_p_data}: got %h expected 000", {err_timeout, ser_p_data});
        end
        accept_word(8'hA5, 1'b1, 1'b0);
        data_valid = 1'b0;
        if (HAS_PAR) check_frame(11'b10101001010, 11, 8'hA5, "midrst_clean");
        else         check_frame(11'b11101001010, 10, 8'hA5, "midrst_clean");
        check_idle("midrst_clean_after");
    endtask

    task automatic test_timeout;
        no_done = 1'b1;
        accept_word(8'h5A, 1'b1, 1'b0);
        data_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({ser_en, busy, err_timeout} !== 3'b110) begin
                errors++;
                $display("FAIL timeout data cycle %0d {ser_en,busy,err}: got %b expected 110", i, {ser_en, busy, err_timeout});
            end
            @(negedge clk);
        end
        checks++;
        if ({err_timeout, TX_OUT, busy, ser_en} !== 4'b1100) begin
            errors++;
            $display("FAIL timeout abort {err,tx,busy,ser_en}: got %b expected 1100", {err_timeout, TX_OUT, busy, ser_en});
        end
        @(negedge clk);
        checks++;
        if ({err_timeout, TX_OUT, busy} !== 3'b010) begin
            errors++;
            $display("FAIL timeout pulse_end {err,tx,busy}: got %b expected 010", {err_timeout, TX_OUT, busy});
        end
        no_done = 1'b0;
        accept_word(8'hC3, 1'b1, 1'b1);
        data_valid = 1'b0;
        check_frame(frame_bits(8'hC3, HAS_PAR, 1'b1), HAS_PAR ? 11 : 10, 8'hC3, "timeout_recover");
        check_idle("timeout_recover_after");
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        test_reset();
        test_frame_a5();
        test_parity_types();
        test_back_to_back();
        test_reset_mid_frame();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, data bits per frame.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 P_DATA  input  DATA_WIDTH  parallel word to transmit; sampled only on accept.
REQ-005 data_valid  input  1  request to send P_DATA.
REQ-006 PAR_EN  input  1  1 = parity bit in frame; sampled on accept.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
REQ-008 ser_done  input  1  from serializer; high in the cycle its last data bit is on ser_data.
REQ-009 ser_data  input  1  serial bit from serializer, LSB first.
REQ-010 ser_en  output  1  serializer shift enable.
REQ-011 ser_p_data  output  DATA_WIDTH  latched word driven to serializer; stable for the whole frame.
REQ-012 TX_OUT  output  1  line output, idle high.
REQ-013 busy  output  1  high from START through STOP inclusive.
REQ-014 err_timeout  output  1  one-cycle pulse on serializer watchdog abort.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; state register one-hot or binary at implementer's choice.
REQ-016 IDLE: TX_OUT=1, busy=0, ser_en=0; data_valid=1 SHALL latch P_DATA, PAR_EN, PAR_TYP, compute parity bit, and enter START next edge.
REQ-017 START: exactly one cycle, TX_OUT=0, busy=1, ser_en=0; then DATA.
REQ-018 DATA: ser_en=1, TX_OUT=ser_data; stays until ser_done=1, then PARITY if latched PAR_EN=1, else STOP.
REQ-019 PARITY: one cycle, ser_en=0, TX_OUT = XOR of latched data (even) or its inverse (odd); then STOP.
REQ-020 STOP: one cycle, TX_OUT=1, busy=1; next IDLE, or START directly if data_valid=1 (word latched in STOP, no idle gap).
REQ-021 data_valid in START, DATA or PARITY SHALL be ignored; no queuing.
REQ-022 Frame length SHALL be DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without, START beginning one edge after accept.
REQ-023 Watchdog counter SHALL count DATA cycles; if ser_done not seen by cycle DATA_WIDTH+2 of DATA, go to IDLE, pulse err_timeout one cycle, TX_OUT=1.
REQ-024 ser_p_data, parity and config latches SHALL change only on accept.
REQ-025 All outputs registered or decoded from state only; no combinational path data_valid -> TX_OUT.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE from any state, including mid-frame, TX_OUT=1, busy=0, ser_en=0, err_timeout=0, ser_p_data=0, watchdog=0.
REQ-027 data_valid coincident with rst SHALL be discarded.

Configuration
REQ-028 Macro UART_TX_PARITY_EN: defined -> PARITY state and PAR_EN/PAR_TYP behaviour per REQ-018/019.
REQ-029 Undefined -> PAR_EN and PAR_TYP ignored, PARITY state and parity logic absent, DATA exits to STOP; frame DATA_WIDTH+2 cycles.

Verification
REQ-030 Macro defined, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle data_valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), busy high 11 cycles.
REQ-031 P_DATA=0x8F, PAR_EN=1, PAR_TYP=1 -> parity bit 0; P_DATA=0x9E, PAR_TYP=0 -> parity bit 1.
REQ-032 0x8F then data_valid held high through STOP with P_DATA=0x9E -> second START on the cycle immediately after the first STOP, no idle-high cycle.
REQ-033 rst pulsed during DATA bit 4 of 0xA5 -> next edge TX_OUT=1, busy=0, ser_en=0; later data_valid starts a clean frame.
REQ-034 Serializer model never asserts ser_done -> err_timeout pulses once after DATA_WIDTH+2 DATA cycles, FSM in IDLE, TX_OUT=1.
REQ-035 Macro undefined, 0xA5 with PAR_EN=1 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1.
